// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio voice path
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_GATE_ON,
    ST_GATE_OFF
  } seq_state_e;

  // Pattern ROM word layout: {rest, note[3:0]}
  localparam int STEP_W   = 5;
  localparam int REST_BIT = 4;
  localparam int NOTE_MSB = 3;

  localparam int SAMPLE_DIV_25M = 521;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a 1-clk strobe every SAMPLE_DIV clocks
module tick_divider #(
  parameter int SAMPLE_DIV = audio_pkg::SAMPLE_DIV_25M
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through the pattern ROM, issuing note index and gate per step
module note_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV   = SAMPLE_DIV_25M,
  parameter int STEP_SAMPLES = 6000,
  parameter int GATE_SAMPLES = 4500,
  parameter int NUM_STEPS    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         restart,
  output logic [$clog2(NUM_STEPS)-1:0] step_addr,
  input  logic [STEP_W-1:0]            step_data,
  output logic                         sample_tick,
  output logic [3:0]                   note_out,
  output logic                         gate_out,
  output logic                         note_valid,
  output logic                         step_wrap
);

  localparam int ADDR_W = $clog2(NUM_STEPS);
  localparam int CNT_W  = $clog2(STEP_SAMPLES);
  localparam logic [CNT_W-1:0]  GATE_LAST = CNT_W'(GATE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_STEPS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] step_idx_q, step_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        note_q, note_d;
  logic              gate_q, gate_d;
  logic              note_valid_q, note_valid_d;
  logic              step_wrap_q, step_wrap_d;

  tick_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (sample_tick)
  );

  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    count_d      = count_q;
    note_d       = note_q;
    gate_d       = gate_q;
    note_valid_d = 1'b0;
    step_wrap_d  = 1'b0;

    // restart beats both a run drop and a same-cycle step advance
    if (restart) begin
      step_idx_d = '0;
      count_d    = '0;
      gate_d     = 1'b0;
      state_d    = run ? ST_FETCH : ST_IDLE;
    end else if (!run && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (run) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          note_d       = step_data[NOTE_MSB:0];
          gate_d       = ~step_data[REST_BIT];
          note_valid_d = 1'b1;
          count_d      = '0;
          state_d      = step_data[REST_BIT] ? ST_GATE_OFF : ST_GATE_ON;
        end
        ST_GATE_ON: if (sample_tick) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == GATE_LAST) begin
            gate_d  = 1'b0;
            state_d = ST_GATE_OFF;
          end
        end
        ST_GATE_OFF: if (sample_tick) begin
          if (count_q == STEP_LAST) begin
            count_d     = '0;
            step_idx_d  = step_idx_q + ADDR_W'(1);
            step_wrap_d = (step_idx_q == IDX_LAST);
            state_d     = ST_FETCH;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_idx_q   <= '0;
      count_q      <= '0;
      note_q       <= '0;
      gate_q       <= 1'b0;
      note_valid_q <= 1'b0;
      step_wrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      count_q      <= count_d;
      note_q       <= note_d;
      gate_q       <= gate_d;
      note_valid_q <= note_valid_d;
      step_wrap_q  <= step_wrap_d;
    end
  end

  assign step_addr  = step_idx_q;
  assign note_out   = note_q;
  assign gate_out   = gate_q;
  assign note_valid = note_valid_q;
  assign step_wrap  = step_wrap_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with a 4-step pattern ROM
module tb_note_sequencer;

  localparam int SD = 4;
  localparam int SS = 5;
  localparam int GS = 3;
  localparam int NS = 4;

  typedef struct packed {
    logic [3:0] note;
    logic       gate;
    logic [1:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] step_addr;
  logic [4:0] step_data = '0;
  logic       sample_tick;
  logic [3:0] note_out;
  logic       gate_out;
  logic       note_valid;
  logic       step_wrap;

  logic [4:0] rom [NS];
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;

  note_sequencer #(
    .SAMPLE_DIV   (SD),
    .STEP_SAMPLES (SS),
    .GATE_SAMPLES (GS),
    .NUM_STEPS    (NS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .restart     (restart),
    .step_addr   (step_addr),
    .step_data   (step_data),
    .sample_tick (sample_tick),
    .note_out    (note_out),
    .gate_out    (gate_out),
    .note_valid  (note_valid),
    .step_wrap   (step_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    rom[0] = {1'b0, 4'h3};
    rom[1] = {1'b1, 4'h5};
    rom[2] = {1'b0, 4'h7};
    rom[3] = {1'b0, 4'hF};
  end

  always @(posedge clk) step_data <= rom[step_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] n, input logic g, input logic [1:0] a);
    exp_t e;
    e.note = n;
    e.gate = g;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every note_valid strobe must match the oldest expected step
  always @(negedge clk) begin
    if (rst_n && note_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_note_valid: got note %0d expected no strobe", note_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("nv_note", note_out, mon_e.note);
        check("nv_gate", gate_out, mon_e.gate);
        check("nv_addr", step_addr, mon_e.addr);
      end
    end
  end

  // Called at a note_valid observation; measures the step and ends at the next note_valid
  task automatic run_step(input int exp_high, input int exp_next, input logic [3:0] nn,
                          input logic ng);
    int high;
    int total;
    int n;
    logic [1:0] start;
    high  = 0;
    total = 0;
    n     = 0;
    start = step_addr;
    while (step_addr == start && n < 100) begin
      if (sample_tick) begin
        total++;
        if (gate_out) high++;
      end
      cyc(1);
      n++;
    end
    check("step_gate_ticks", high, exp_high);
    check("step_total_ticks", total, SS);
    check("step_next_addr", step_addr, exp_next);
    check("step_wrap", step_wrap, (exp_next == 0) ? 1 : 0);
    push_exp(nn, ng, 2'(exp_next));
    cyc(2);
    check("next_note_valid", note_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ticks;
    int last;
    int spacing_bad;
    int activity;
    int total;
    int n;
    int wrap_seen;

    cyc(3);
    check("rst_note", note_out, 0);
    check("rst_gate", gate_out, 0);
    check("rst_nv", note_valid, 0);
    check("rst_addr", step_addr, 0);
    check("rst_wrap", step_wrap, 0);
    check("rst_tick", sample_tick, 0);
    rst_n = 1'b1;

    // 1: idle divider
    ticks = 0; last = -1; spacing_bad = 0; activity = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (sample_tick) begin
        if (last >= 0 && (i - last) != SD) spacing_bad++;
        last = i;
        ticks++;
      end
      if (gate_out || note_valid || step_addr != 2'd0) activity++;
    end
    check("idle_tick_count", ticks, 4);
    check("idle_tick_spacing", spacing_bad, 0);
    check("idle_activity", activity, 0);

    // 2-4: start and run through a full pattern with wrap
    run = 1'b1;
    push_exp(4'h3, 1'b1, 2'd0);
    cyc(3);
    check("run_latency_nv", note_valid, 1);
    run_step(3, 1, 4'h5, 1'b0);
    run_step(0, 2, 4'h7, 1'b1);
    run_step(3, 3, 4'hF, 1'b1);
    run_step(3, 0, 4'h3, 1'b1);

    // 5: restart on the step-3 end tick
    run_step(3, 1, 4'h5, 1'b0);
    run_step(0, 2, 4'h7, 1'b1);
    run_step(3, 3, 4'hF, 1'b1);
    total = 0; n = 0;
    while (n < 100) begin
      if (sample_tick) begin
        total++;
        if (total == SS) break;
      end
      cyc(1);
      n++;
    end
    check("restart_tick_reached", total, SS);
    check("restart_at_addr", step_addr, 3);
    restart = 1'b1;
    push_exp(4'h3, 1'b1, 2'd0);
    cyc(1);
    restart = 1'b0;
    wrap_seen = int'(step_wrap);
    check("restart_addr", step_addr, 0);
    check("restart_gate", gate_out, 0);
    cyc(1);
    wrap_seen += int'(step_wrap);
    cyc(1);
    wrap_seen += int'(step_wrap);
    check("restart_latency_nv", note_valid, 1);
    check("restart_no_wrap", wrap_seen, 0);

    // 6: pause mid-gate, resume, then async reset
    run_step(3, 1, 4'h5, 1'b0);
    run_step(0, 2, 4'h7, 1'b1);
    check("pause_gate_before", gate_out, 1);
    run = 1'b0;
    cyc(1);
    check("pause_gate", gate_out, 0);
    check("pause_addr", step_addr, 2);
    check("pause_note", note_out, 7);
    cyc(3);
    check("paused_gate", gate_out, 0);
    check("paused_nv", note_valid, 0);
    check("paused_addr", step_addr, 2);
    run = 1'b1;
    push_exp(4'h7, 1'b1, 2'd2);
    cyc(3);
    check("resume_nv", note_valid, 1);
    cyc(2);
    check("pre_reset_gate", gate_out, 1);
    #2;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("async_rst_gate", gate_out, 0);
    check("async_rst_note", note_out, 0);
    check("async_rst_addr", step_addr, 0);
    check("async_rst_nv", note_valid, 0);
    check("async_rst_tick", sample_tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
